io_bank_bridge: RTL and testbench
=================================

// Module: io_bank_bridge
// PURPOSE
//  Parametrised successor to the fixed 8-bank MCS I/O bus decoder. Sits between mcs IO bus and peripheral
//  banks (PS2IF, VGAIF, graphics, camera...). Decodes bank from IO_Address, issues one-cycle WR/RD strobes,
//  and generates IO_Ready either after a fixed latency or on a per-bank ready handshake. Unanswered access
//  times out with an error word. Read data is muxed from a flattened bus.
// PARAMETERS
//  NBANK      8           number of peripheral banks, 1..16
//  BANK_LSB   24          lowest IO_Address bit of the bank field; field width BSW=clog2(NBANK) (min 1)
//  FIXED_LAT  1           cycles from RD/WR pulse to data capture for banks with BANK_WAIT=0; >=1
//  TIMEOUT    256         max cycles in ACC for BANK_WAIT=1 banks before forced response; >=2
//  ERR_DATA   32'hDEAD_BEEF read data returned on timeout or out-of-range bank
// PORTS
//  CLK             in   1        system clock (50 MHz)
//  RST             in   1        synchronous reset, active-high
//  IO_Address      in   32       mcs I/O address
//  IO_Addr_Strobe  in   1        mcs address strobe
//  IO_Read_Strobe  in   1        mcs read strobe
//  IO_Write_Strobe in   1        mcs write strobe
//  IO_Read_Data    out  32       read data to mcs; valid only while IO_Ready=1
//  IO_Ready        out  1        one-cycle completion pulse to mcs
//  WR              out  NBANK    one-hot one-cycle write strobe per bank
//  RD              out  NBANK    one-hot one-cycle read strobe per bank
//  RDATA           in   32*NBANK bank b read data at RDATA[32*b+:32]
//  BANK_WAIT       in   NBANK    static: 1 = bank b completes via BANK_RDY, 0 = fixed latency
//  BANK_RDY        in   NBANK    bank b completion (level, sampled only in ACC for current bank)
//  ERR_CLR         in   1        clears ERR_TO/ERR_BANK
//  ERR_TO          out  1        sticky timeout / out-of-range flag
//  ERR_BANK        out  BSW      bank index of most recent error
// BEHAVIOUR
//  - Reset: state IDLE; IO_Ready=0, IO_Read_Data=0, WR=0, RD=0, ERR_TO=0, ERR_BANK=0, counters 0.
//    Reset mid-access abandons it: no IO_Ready is issued for that access.
//  - FSM IDLE -> ACC -> RESP -> IDLE. Strobes accepted only in IDLE; strobes in ACC/RESP ignored.
//  - IDLE, cycle 0: IO_Addr_Strobe & (Read|Write) latches bank b=IO_Address[BANK_LSB+:BSW] and direction.
//    Both Read and Write high: treated as write. b<NBANK -> ACC; b>=NBANK -> RESP directly, no WR/RD,
//    read data ERR_DATA, ERR_TO set, ERR_BANK=b truncated to BSW.
//  - Cycle 1 (first ACC cycle): WR[b] or RD[b] high exactly one cycle. Cycle counter cnt=0 here.
//  - BANK_WAIT[b]=0: at cnt==FIXED_LAT-1 capture RDATA[b] -> RESP. IO_Ready at cycle 1+FIXED_LAT.
//  - BANK_WAIT[b]=1: first ACC cycle with BANK_RDY[b]=1 (may be cycle 1) captures RDATA[b] -> RESP;
//    IO_Ready the following cycle. Other banks' BANK_RDY ignored.
//  - RESP: IO_Ready=1 one cycle; IO_Read_Data=captured word on reads, 0 on writes; 0 outside RESP.
//  - cnt saturates; never wraps. ERR_CLR and new error same cycle: error wins (ERR_TO=1).
// CONFIGURATION
//  IO_BANK_BRIDGE_TIMEOUT_EN defined: in ACC for a BANK_WAIT bank, cnt==TIMEOUT-1 without BANK_RDY
//    -> RESP with IO_Read_Data=ERR_DATA (reads), ERR_TO=1, ERR_BANK=b. BANK_RDY on that same cycle wins.
//  Not defined: ACC waits indefinitely for BANK_RDY; timeout counter not built; ERR_TO/ERR_BANK set
//    only by out-of-range banks.
// TESTING
//  - Read bank3, BANK_WAIT=0, FIXED_LAT=1, RDATA[3]=32'h0000_00A5 -> RD[3] cycle1, IO_Ready cycle2, data 0xA5.
//  - Write bank4, FIXED_LAT=3 -> WR=8'h10 one cycle at cycle1, IO_Ready at cycle4, IO_Read_Data=0.
//  - Read bank2, BANK_WAIT=1, BANK_RDY[2] at cycle6 (BANK_RDY[5] at cycle3) -> IO_Ready cycle7 only.
//  - TIMEOUT_EN, TIMEOUT=16, bank5 never ready -> IO_Ready cycle17, data 0xDEADBEEF, ERR_TO=1, ERR_BANK=5;
//    ERR_CLR pulse -> ERR_TO=0.
//  - NBANK=6, access bank7 -> no WR/RD, IO_Ready cycle1, data 0xDEADBEEF, ERR_BANK=7.
//  - RST high during ACC of wait-bank access -> no IO_Ready; next read of bank0 completes normally.

Source files
------------

// File: rtl/io_bank_bridge.sv
// io_bank_bridge: bridges the MCS I/O bus to NBANK peripheral banks. Each bank completes after a fixed latency or through a ready handshake.
// Optional feature: define IO_BANK_BRIDGE_TIMEOUT_EN to bound handshake waits at TIMEOUT cycles.
module io_bank_bridge #(
   parameter int          NBANK     = 8,
   parameter int          BANK_LSB  = 24,
   parameter int          FIXED_LAT = 1,
   parameter int          TIMEOUT   = 256,
   parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
   localparam int         BSW       = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [31:0]         i_io_address,
   input  logic                i_io_addr_strobe,
   input  logic                i_io_read_strobe,
   input  logic                i_io_write_strobe,
   output logic [31:0]         o_io_read_data,
   output logic                o_io_ready,
   output logic [NBANK-1:0]    o_wr,
   output logic [NBANK-1:0]    o_rd,
   input  logic [32*NBANK-1:0] i_rdata,
   input  logic [NBANK-1:0]    i_bank_wait,
   input  logic [NBANK-1:0]    i_bank_rdy,
   input  logic                i_err_clr,
   output logic                o_err_to,
   output logic [BSW-1:0]      o_err_bank
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

`ifdef IO_BANK_BRIDGE_TIMEOUT_EN
   localparam int CNT_MAX = (TIMEOUT > FIXED_LAT) ? TIMEOUT : FIXED_LAT;
`else
   localparam int CNT_MAX = FIXED_LAT;
`endif
   localparam int            CW       = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(FIXED_LAT - 1);

   state_t             r_state;
   state_t             w_next;
   logic [BSW-1:0]     r_bank;
   logic               r_write;
   logic [CW-1:0]      r_cnt;
   logic [31:0]        r_rdata;
   logic               r_err_to;
   logic [BSW-1:0]     r_err_bank;

   logic               w_start;
   logic [BSW-1:0]     w_in_bank;
   logic               w_in_range;
   logic [NBANK-1:0]   w_sel;
   logic               w_wait;
   logic               w_rdy;
   logic               w_done;
   logic               w_tmo;
   logic               w_set_err;
   logic [BSW-1:0]     w_err_bank;
   logic [31:0]        w_bank_data;
   logic               w_unused_addr;

   // Only the bank field of the address matters; the rest is folded away.
   assign w_unused_addr = ^i_io_address;

   assign w_start    = i_io_addr_strobe & (i_io_read_strobe | i_io_write_strobe);
   assign w_in_bank  = i_io_address[BANK_LSB +: BSW];
   assign w_in_range = ({1'b0, w_in_bank} < (BSW + 1)'(NBANK));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_sel       = '0;
      w_bank_data = '0;
      for (int b = 0; b < NBANK; b++) begin
         w_sel[b] = (r_bank == BSW'(b));
         if (r_bank == BSW'(b)) w_bank_data = i_rdata[32*b +: 32];
      end
   end

   assign w_wait = |(i_bank_wait & w_sel);
   assign w_rdy  = |(i_bank_rdy & w_sel);
   assign w_done = (r_state == S_ACC) & (w_wait ? w_rdy : (r_cnt == LAT_LAST));

`ifdef IO_BANK_BRIDGE_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   // A ready arriving on the last allowed cycle still completes normally.
   assign w_tmo = (r_state == S_ACC) & w_wait & ~w_rdy & (r_cnt == TO_LAST);
`else
   assign w_tmo = 1'b0;
`endif

   assign w_set_err  = ((r_state == S_IDLE) & w_start & ~w_in_range) | w_tmo;
   assign w_err_bank = (r_state == S_IDLE) ? w_in_bank : r_bank;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = w_in_range ? S_ACC : S_RESP;
         S_ACC:   if (w_done || w_tmo) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // The strobe is issued only in the first ACC cycle. The counter saturates, so it reads zero only there.
   always_comb begin
      o_io_ready     = 1'b0;
      o_io_read_data = '0;
      o_wr           = '0;
      o_rd           = '0;
      case (r_state)
         S_ACC: begin
            if (r_cnt == '0) begin
               if (r_write) o_wr = w_sel;
               else         o_rd = w_sel;
            end
         end
         S_RESP: begin
            o_io_ready = 1'b1;
            if (!r_write) o_io_read_data = r_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bank     <= '0;
         r_write    <= 1'b0;
         r_cnt      <= '0;
         r_rdata    <= '0;
         r_err_to   <= 1'b0;
         r_err_bank <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            r_cnt <= '0;
            if (w_start) begin
               r_bank  <= w_in_bank;
               r_write <= i_io_write_strobe;
               if (!w_in_range) r_rdata <= ERR_DATA;
            end
         end else if (r_state == S_ACC) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (w_done)     r_rdata <= w_bank_data;
            else if (w_tmo) r_rdata <= ERR_DATA;
         end
         // A new error outranks a simultaneous clear.
         if (w_set_err) begin
            r_err_to   <= 1'b1;
            r_err_bank <= w_err_bank;
         end else if (i_err_clr) begin
            r_err_to   <= 1'b0;
            r_err_bank <= '0;
         end
      end
   end

   assign o_err_to   = r_err_to;
   assign o_err_bank = r_err_bank;

endmodule

// File: tb/tb_io_bank_bridge.sv
// tb_io_bank_bridge: directed checks of io_bank_bridge on two configurations.
// Instance A has 8 banks and FIXED_LAT=1. Instance B has 6 banks and FIXED_LAT=3.
module tb_io_bank_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: NBANK=8, FIXED_LAT=1, TIMEOUT=16
   logic         a_rst, a_as, a_rs, a_ws, a_err_clr;
   logic [31:0]  a_addr;
   logic [255:0] a_rdata;
   logic [7:0]   a_wait, a_rdy;
   logic [31:0]  a_rd_data;
   logic         a_ready, a_err_to;
   logic [7:0]   a_wr, a_rd;
   logic [2:0]   a_err_bank;

   // Instance B: NBANK=6, FIXED_LAT=3
   logic         b_rst, b_as, b_rs, b_ws, b_err_clr;
   logic [31:0]  b_addr;
   logic [191:0] b_rdata;
   logic [5:0]   b_wait, b_rdy;
   logic [31:0]  b_rd_data;
   logic         b_ready, b_err_to;
   logic [5:0]   b_wr, b_rd;
   logic [2:0]   b_err_bank;

   io_bank_bridge #(.NBANK(8), .BANK_LSB(24), .FIXED_LAT(1), .TIMEOUT(16)) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_io_address(a_addr), .i_io_addr_strobe(a_as),
      .i_io_read_strobe(a_rs), .i_io_write_strobe(a_ws), .o_io_read_data(a_rd_data),
      .o_io_ready(a_ready), .o_wr(a_wr), .o_rd(a_rd), .i_rdata(a_rdata),
      .i_bank_wait(a_wait), .i_bank_rdy(a_rdy), .i_err_clr(a_err_clr),
      .o_err_to(a_err_to), .o_err_bank(a_err_bank));

   io_bank_bridge #(.NBANK(6), .BANK_LSB(24), .FIXED_LAT(3), .TIMEOUT(16)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_io_address(b_addr), .i_io_addr_strobe(b_as),
      .i_io_read_strobe(b_rs), .i_io_write_strobe(b_ws), .o_io_read_data(b_rd_data),
      .o_io_ready(b_ready), .o_wr(b_wr), .o_rd(b_rd), .i_rdata(b_rdata),
      .i_bank_wait(b_wait), .i_bank_rdy(b_rdy), .i_err_clr(b_err_clr),
      .o_err_to(b_err_to), .o_err_bank(b_err_bank));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; drive and sample 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b1; a_as = 1'b0; a_rs = 1'b0; a_ws = 1'b0; a_err_clr = 1'b0;
      a_addr = '0; a_rdata = '0; a_wait = 8'b0010_0100; a_rdy = '0;
      b_rst = 1'b1; b_as = 1'b0; b_rs = 1'b0; b_ws = 1'b0; b_err_clr = 1'b0;
      b_addr = '0; b_rdata = '0; b_wait = '0; b_rdy = '0;
      a_rdata[32*0 +: 32] = 32'h600D_0000;
      a_rdata[32*2 +: 32] = 32'h1234_5678;
      a_rdata[32*3 +: 32] = 32'h0000_00A5;
      a_rdata[32*5 +: 32] = 32'hCAFE_0005;
      b_rdata[32*1 +: 32] = 32'h0000_1111;
      step(); step();

      // Reset state
      check("rst_ready",    {31'd0, a_ready},   32'd0);
      check("rst_data",     a_rd_data,          32'd0);
      check("rst_wr",       {24'd0, a_wr},      32'd0);
      check("rst_rd",       {24'd0, a_rd},      32'd0);
      check("rst_err_to",   {31'd0, a_err_to},  32'd0);
      check("rst_err_bank", {29'd0, a_err_bank}, 32'd0);
      a_rst = 1'b0; b_rst = 1'b0;
      step();

      // Read bank3, fixed latency 1: RD at cycle 1, ready with 0xA5 at cycle 2
      a_addr = 32'h0300_0000; a_as = 1'b1; a_rs = 1'b1;
      step();
      a_as = 1'b0; a_rs = 1'b0;
      check("r3_c1_rd",    {24'd0, a_rd},    32'h08);
      check("r3_c1_wr",    {24'd0, a_wr},    32'h00);
      check("r3_c1_ready", {31'd0, a_ready}, 32'd0);
      step();
      check("r3_c2_ready", {31'd0, a_ready}, 32'd1);
      check("r3_c2_data",  a_rd_data,        32'h0000_00A5);
      check("r3_c2_rd",    {24'd0, a_rd},    32'h00);
      step();
      check("r3_c3_ready", {31'd0, a_ready}, 32'd0);
      check("r3_c3_data",  a_rd_data,        32'd0);

      // Write bank4, fixed latency 3: WR one cycle, ready at cycle 4, data 0. Strobes during ACC are ignored.
      b_addr = 32'h0400_0000; b_as = 1'b1; b_ws = 1'b1;
      step();
      b_as = 1'b0; b_ws = 1'b0;
      check("w4_c1_wr",    {26'd0, b_wr},    32'h10);
      check("w4_c1_rd",    {26'd0, b_rd},    32'h00);
      check("w4_c1_ready", {31'd0, b_ready}, 32'd0);
      step();
      b_addr = 32'h0100_0000; b_as = 1'b1; b_rs = 1'b1;
      check("w4_c2_wr",    {26'd0, b_wr},    32'h00);
      check("w4_c2_ready", {31'd0, b_ready}, 32'd0);
      step();
      b_as = 1'b0; b_rs = 1'b0;
      check("w4_c3_ready", {31'd0, b_ready}, 32'd0);
      check("w4_c3_rd",    {26'd0, b_rd},    32'h00);
      step();
      check("w4_c4_ready", {31'd0, b_ready}, 32'd1);
      check("w4_c4_data",  b_rd_data,        32'd0);
      step();
      check("w4_c5_ready", {31'd0, b_ready}, 32'd0);
      check("w4_c5_rd",    {26'd0, b_rd},    32'h00);

      // Read bank2 (wait): BANK_RDY[5] at cycle 3 is ignored, BANK_RDY[2] at cycle 6 gives ready at cycle 7
      a_addr = 32'h0200_0000; a_as = 1'b1; a_rs = 1'b1;
      step();
      a_as = 1'b0; a_rs = 1'b0;
      check("r2_c1_rd", {24'd0, a_rd}, 32'h04);
      for (int cyc = 2; cyc <= 6; cyc++) begin
         step();
         check($sformatf("r2_c%0d_ready", cyc), {31'd0, a_ready}, 32'd0);
         a_rdy = (cyc == 3) ? 8'h20 : (cyc == 6) ? 8'h04 : 8'h00;
      end
      step();
      a_rdy = '0;
      check("r2_c7_ready", {31'd0, a_ready}, 32'd1);
      check("r2_c7_data",  a_rd_data,        32'h1234_5678);
      step();
      check("r2_c8_ready", {31'd0, a_ready}, 32'd0);

      // Read bank5 (wait), never ready
      a_addr = 32'h0500_0000; a_as = 1'b1; a_rs = 1'b1;
      step();
      a_as = 1'b0; a_rs = 1'b0;
`ifdef IO_BANK_BRIDGE_TIMEOUT_EN
      for (int cyc = 1; cyc <= 16; cyc++) begin
         check($sformatf("to_c%0d_ready", cyc), {31'd0, a_ready}, 32'd0);
         if (cyc < 16) step();
      end
      step();
      check("to_c17_ready",    {31'd0, a_ready},    32'd1);
      check("to_c17_data",     a_rd_data,           32'hDEAD_BEEF);
      check("to_c17_err_to",   {31'd0, a_err_to},   32'd1);
      check("to_c17_err_bank", {29'd0, a_err_bank}, 32'd5);
      step();
      a_err_clr = 1'b1;
      step();
      a_err_clr = 1'b0;
      check("to_clr_err_to",   {31'd0, a_err_to},   32'd0);
      check("to_clr_err_bank", {29'd0, a_err_bank}, 32'd0);
`else
      for (int cyc = 1; cyc <= 30; cyc++) begin
         check($sformatf("nw_c%0d_ready", cyc), {31'd0, a_ready}, 32'd0);
         step();
      end
      check("nw_err_to", {31'd0, a_err_to}, 32'd0);
      a_rdy = 8'h20;
      step();
      a_rdy = '0;
      check("nw_ready", {31'd0, a_ready}, 32'd1);
      check("nw_data",  a_rd_data,        32'hCAFE_0005);
      step();
`endif

      // Out-of-range bank7 on the 6-bank instance, with ERR_CLR in the same cycle
      b_addr = 32'h0700_0000; b_as = 1'b1; b_rs = 1'b1; b_err_clr = 1'b1;
      step();
      b_as = 1'b0; b_rs = 1'b0; b_err_clr = 1'b0;
      check("oor_c1_ready",    {31'd0, b_ready},    32'd1);
      check("oor_c1_wr",       {26'd0, b_wr},       32'h00);
      check("oor_c1_rd",       {26'd0, b_rd},       32'h00);
      check("oor_c1_data",     b_rd_data,           32'hDEAD_BEEF);
      check("oor_c1_err_to",   {31'd0, b_err_to},   32'd1);
      check("oor_c1_err_bank", {29'd0, b_err_bank}, 32'd7);
      step();
      check("oor_c2_ready",    {31'd0, b_ready},    32'd0);
      b_err_clr = 1'b1;
      step();
      b_err_clr = 1'b0;
      check("oor_clr_err_to",  {31'd0, b_err_to},   32'd0);

      // Reset during ACC of a wait-bank read, with ready in the same cycle: no IO_Ready
      a_addr = 32'h0200_0000; a_as = 1'b1; a_rs = 1'b1;
      step();
      a_as = 1'b0; a_rs = 1'b0;
      check("rr_c1_rd", {24'd0, a_rd}, 32'h04);
      step();
      a_rst = 1'b1; a_rdy = 8'h04;
      step();
      a_rst = 1'b0; a_rdy = '0;
      check("rr_c3_ready", {31'd0, a_ready}, 32'd0);
      step();
      check("rr_c4_ready", {31'd0, a_ready}, 32'd0);
      a_addr = 32'h0000_0000; a_as = 1'b1; a_rs = 1'b1;
      step();
      a_as = 1'b0; a_rs = 1'b0;
      check("rr_b0_rd",    {24'd0, a_rd},    32'h01);
      step();
      check("rr_b0_ready", {31'd0, a_ready}, 32'd1);
      check("rr_b0_data",  a_rd_data,        32'h600D_0000);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
